// File: rtl/misere_pkg.sv
// Shared symbols, result codes and state encodings for the Wild Misere N-in-a-row engine.
package misere_pkg;

    localparam logic [1:0] SYM_EMPTY = 2'b00;
    localparam logic [1:0] SYM_X     = 2'b01;
    localparam logic [1:0] SYM_O     = 2'b10;

    localparam logic [1:0] RES_NONE  = 2'b00;
    localparam logic [1:0] RES_P1    = 2'b01;
    localparam logic [1:0] RES_P2    = 2'b10;
    localparam logic [1:0] RES_TIE   = 2'b11;

    typedef enum logic [2:0] {S_WAIT, S_PLACE, S_SCAN, S_DRAW, S_NEXT, S_OVER} state_t;

    typedef enum logic [1:0] {DIR_H, DIR_V, DIR_D, DIR_A} dir_t;

    function automatic logic sym_legal(input logic [1:0] s);
        return (s == SYM_X) || (s == SYM_O);
    endfunction

endpackage

// File: rtl/misere_line_scan.sv
// Sequential line walk through the last-placed cell; one board probe per cycle.
// done/loss are combinational and valid on the cycle of the deciding probe.
module misere_line_scan
    import misere_pkg::*;
#(
    parameter int BOARD_N = 3,
    parameter int WIN_LEN = 3,
    parameter int POS_W   = $clog2(BOARD_N*BOARD_N)
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [POS_W-1:0] origin,
    input  logic [1:0]       origin_sym,
    output logic [POS_W-1:0] probe_pos,
    input  logic [1:0]       probe_sym,
    output logic             done,
    output logic             loss
);
    localparam int STEP_W = $clog2(WIN_LEN);
    localparam logic signed [5:0] N_S = 6'(BOARD_N);

    logic              busy;
    logic              side;
    dir_t              dir;
    logic [STEP_W-1:0] step;
    logic [3:0]        run;
    logic signed [5:0] org_r, org_c;
    logic signed [5:0] dr, dc, k_s, cr, cc;
    logic [7:0]        lin;
    logic              in_bounds, match, side_end, hit, last_side;

    always_comb begin
        dr = 6'sd0;
        dc = 6'sd0;
        unique case (dir)
            DIR_H: dc = 6'sd1;
            DIR_V: dr = 6'sd1;
            DIR_D: begin dr = 6'sd1;  dc = 6'sd1; end
            DIR_A: begin dr = -6'sd1; dc = 6'sd1; end
            default: ;
        endcase
        k_s = 6'(step);
        if (side) k_s = -k_s;
        cr = org_r + dr * k_s;
        cc = org_c + dc * k_s;
        in_bounds = (cr >= 6'sd0) && (cr < N_S) && (cc >= 6'sd0) && (cc < N_S);
        lin = 8'(cr[2:0]) * 8'(BOARD_N) + 8'(cc[2:0]);
        probe_pos = in_bounds ? POS_W'(lin) : '0;
        match     = in_bounds && (probe_sym == origin_sym);
        hit       = match && ((run + 4'd1) >= 4'(WIN_LEN));
        side_end  = !match || (step == STEP_W'(WIN_LEN-1));
        last_side = side && (dir == DIR_A);
        done      = busy && (hit || (side_end && last_side));
        loss      = busy && hit;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            busy  <= 1'b0;
            side  <= 1'b0;
            dir   <= DIR_H;
            step  <= STEP_W'(1);
            run   <= 4'd1;
            org_r <= 6'sd0;
            org_c <= 6'sd0;
        end else if (start) begin
            busy  <= 1'b1;
            side  <= 1'b0;
            dir   <= DIR_H;
            step  <= STEP_W'(1);
            run   <= 4'd1;
            org_r <= 6'(int'(origin) / BOARD_N);
            org_c <= 6'(int'(origin) % BOARD_N);
        end else if (busy) begin
            if (done) begin
                busy <= 1'b0;
            end else begin
                if (match) run <= run + 4'd1;
                if (side_end) begin
                    step <= STEP_W'(1);
                    if (!side) begin
                        side <= 1'b1;
                    end else begin
                        // run restarts at 1 for the next direction through the origin
                        side <= 1'b0;
                        dir  <= dir_t'(dir + 2'd1);
                        run  <= 4'd1;
                    end
                end else begin
                    step <= step + STEP_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/misere_board_ctrl.sv
// Game-state engine for Wild Misere N-in-a-row: move handshake, board store, loss scan, redraw requests.
// Optional single-level undo is compiled in with MISERE_UNDO_EN.
module misere_board_ctrl
    import misere_pkg::*;
#(
    parameter  int BOARD_N = 3,
    parameter  int WIN_LEN = 3,
    localparam int POS_W   = $clog2(BOARD_N*BOARD_N),
    localparam int CNT_W   = $clog2(BOARD_N*BOARD_N+1)
) (
    input  logic             clock,
    input  logic             resetn,
`ifdef MISERE_UNDO_EN
    input  logic             undo_req,
`endif
    input  logic             move_valid,
    output logic             move_ready,
    input  logic [POS_W-1:0] move_pos,
    input  logic [1:0]       move_sym,
    output logic             move_err,
    output logic             draw_req,
    input  logic             draw_ack,
    output logic [POS_W-1:0] draw_pos,
    output logic [1:0]       draw_sym,
    input  logic [POS_W-1:0] rd_pos,
    output logic [1:0]       rd_sym,
    output logic             turn,
    output logic             game_over,
    output logic [1:0]       result,
    output logic [CNT_W-1:0] move_count
);
    localparam int CELLS = BOARD_N*BOARD_N;

    state_t           state;
    logic [1:0]       board [CELLS];
    logic [POS_W-1:0] lat_pos;
    logic [1:0]       lat_sym;
    logic             loss_flag;
    logic             move_ok;
    logic             scan_start, scan_done, scan_loss;
    logic [POS_W-1:0] probe_pos;
    logic [1:0]       probe_sym;
`ifdef MISERE_UNDO_EN
    logic             undo_avail;
    logic             undo_mode;
`endif

    assign move_ready = (state == S_WAIT);
    assign scan_start = (state == S_PLACE);
    assign probe_sym  = board[probe_pos];

    always_comb begin
        rd_sym = SYM_EMPTY;
        if (int'(rd_pos) < CELLS) rd_sym = board[rd_pos];
        move_ok = 1'b0;
        if (int'(move_pos) < CELLS)
            move_ok = sym_legal(move_sym) && (board[move_pos] == SYM_EMPTY);
    end

    misere_line_scan #(.BOARD_N(BOARD_N), .WIN_LEN(WIN_LEN), .POS_W(POS_W)) u_scan (
        .clock      (clock),
        .resetn     (resetn),
        .start      (scan_start),
        .origin     (lat_pos),
        .origin_sym (lat_sym),
        .probe_pos  (probe_pos),
        .probe_sym  (probe_sym),
        .done       (scan_done),
        .loss       (scan_loss)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state      <= S_WAIT;
            for (int i = 0; i < CELLS; i++) board[i] <= SYM_EMPTY;
            lat_pos    <= '0;
            lat_sym    <= SYM_EMPTY;
            loss_flag  <= 1'b0;
            turn       <= 1'b0;
            game_over  <= 1'b0;
            result     <= RES_NONE;
            move_count <= '0;
            move_err   <= 1'b0;
            draw_req   <= 1'b0;
            draw_pos   <= '0;
            draw_sym   <= SYM_EMPTY;
`ifdef MISERE_UNDO_EN
            undo_avail <= 1'b0;
            undo_mode  <= 1'b0;
`endif
        end else begin
            move_err <= 1'b0;
            unique case (state)
                S_WAIT: begin
                    if (move_valid) begin
                        if (move_ok) begin
                            lat_pos <= move_pos;
                            lat_sym <= move_sym;
                            state   <= S_PLACE;
                        end else begin
                            move_err <= 1'b1;
                        end
                    end
`ifdef MISERE_UNDO_EN
                    else if (undo_req) begin
                        // lat_pos still holds the last accepted cell
                        if (undo_avail && (move_count != '0)) begin
                            board[lat_pos] <= SYM_EMPTY;
                            move_count     <= move_count - CNT_W'(1);
                            turn           <= ~turn;
                            draw_pos       <= lat_pos;
                            draw_sym       <= SYM_EMPTY;
                            draw_req       <= 1'b1;
                            undo_mode      <= 1'b1;
                            undo_avail     <= 1'b0;
                            state          <= S_DRAW;
                        end else begin
                            move_err <= 1'b1;
                        end
                    end
`endif
                end
                S_PLACE: begin
                    board[lat_pos] <= lat_sym;
                    move_count     <= move_count + CNT_W'(1);
                    draw_pos       <= lat_pos;
                    draw_sym       <= lat_sym;
                    loss_flag      <= 1'b0;
`ifdef MISERE_UNDO_EN
                    undo_avail     <= 1'b1;
`endif
                    state          <= S_SCAN;
                end
                S_SCAN: begin
                    if (scan_done) begin
                        loss_flag <= scan_loss;
                        draw_req  <= 1'b1;
                        state     <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    if (draw_ack) begin
                        draw_req <= 1'b0;
`ifdef MISERE_UNDO_EN
                        if (undo_mode) begin
                            undo_mode <= 1'b0;
                            state     <= S_WAIT;
                        end else
`endif
                        if (loss_flag) begin
                            // loss takes precedence over a full board
                            game_over <= 1'b1;
                            result    <= turn ? RES_P1 : RES_P2;
                            state     <= S_OVER;
                        end else if (move_count == CNT_W'(CELLS)) begin
                            game_over <= 1'b1;
                            result    <= RES_TIE;
                            state     <= S_OVER;
                        end else begin
                            state <= S_NEXT;
                        end
                    end
                end
                S_NEXT: begin
                    turn  <= ~turn;
                    state <= S_WAIT;
                end
                S_OVER: ;
                default: state <= S_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_misere_board_ctrl.sv
// Directed bench: 3x3/3 engine (dut a) and 5x5/4 engine (dut b) on a shared clock and reset.
module tb_misere_board_ctrl;
    import misere_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic resetn;

    logic       a_valid, a_ready, a_err, a_req, a_ack, a_turn, a_over;
    logic [3:0] a_pos, a_dpos, a_rdpos, a_cnt;
    logic [1:0] a_sym, a_dsym, a_rdsym, a_res;
    logic       b_valid, b_ready, b_err, b_req, b_ack, b_turn, b_over;
    logic [4:0] b_pos, b_dpos, b_rdpos, b_cnt;
    logic [1:0] b_sym, b_dsym, b_rdsym, b_res;
`ifdef MISERE_UNDO_EN
    logic a_undo, b_undo;
`endif

    misere_board_ctrl #(.BOARD_N(3), .WIN_LEN(3)) dut_a (
        .clock(clock), .resetn(resetn),
`ifdef MISERE_UNDO_EN
        .undo_req(a_undo),
`endif
        .move_valid(a_valid), .move_ready(a_ready), .move_pos(a_pos), .move_sym(a_sym),
        .move_err(a_err), .draw_req(a_req), .draw_ack(a_ack), .draw_pos(a_dpos),
        .draw_sym(a_dsym), .rd_pos(a_rdpos), .rd_sym(a_rdsym), .turn(a_turn),
        .game_over(a_over), .result(a_res), .move_count(a_cnt)
    );

    misere_board_ctrl #(.BOARD_N(5), .WIN_LEN(4)) dut_b (
        .clock(clock), .resetn(resetn),
`ifdef MISERE_UNDO_EN
        .undo_req(b_undo),
`endif
        .move_valid(b_valid), .move_ready(b_ready), .move_pos(b_pos), .move_sym(b_sym),
        .move_err(b_err), .draw_req(b_req), .draw_ack(b_ack), .draw_pos(b_dpos),
        .draw_sym(b_dsym), .rd_pos(b_rdpos), .rd_sym(b_rdsym), .turn(b_turn),
        .game_over(b_over), .result(b_res), .move_count(b_cnt)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] g_ready(input int d); return (d == 0) ? 32'(a_ready) : 32'(b_ready); endfunction
    function automatic logic [31:0] g_err(input int d);   return (d == 0) ? 32'(a_err)   : 32'(b_err);   endfunction
    function automatic logic [31:0] g_req(input int d);   return (d == 0) ? 32'(a_req)   : 32'(b_req);   endfunction
    function automatic logic [31:0] g_dpos(input int d);  return (d == 0) ? 32'(a_dpos)  : 32'(b_dpos);  endfunction
    function automatic logic [31:0] g_dsym(input int d);  return (d == 0) ? 32'(a_dsym)  : 32'(b_dsym);  endfunction
    function automatic logic [31:0] g_turn(input int d);  return (d == 0) ? 32'(a_turn)  : 32'(b_turn);  endfunction
    function automatic logic [31:0] g_over(input int d);  return (d == 0) ? 32'(a_over)  : 32'(b_over);  endfunction
    function automatic logic [31:0] g_res(input int d);   return (d == 0) ? 32'(a_res)   : 32'(b_res);   endfunction
    function automatic logic [31:0] g_cnt(input int d);   return (d == 0) ? 32'(a_cnt)   : 32'(b_cnt);   endfunction

    task automatic rd_chk(input int d, input int pos, input logic [1:0] exp, input string tag);
        if (d == 0) a_rdpos = 4'(pos); else b_rdpos = 5'(pos);
        #1;
        chk(tag, (d == 0) ? 32'(a_rdsym) : 32'(b_rdsym), 32'(exp));
    endtask

    // offers one move; returns on the negedge after the transfer edge
    task automatic offer(input int d, input int pos, input logic [1:0] sym);
        @(negedge clock);
        if (d == 0) begin a_valid = 1'b1; a_pos = 4'(pos); a_sym = sym; end
        else        begin b_valid = 1'b1; b_pos = 5'(pos); b_sym = sym; end
        @(negedge clock);
        if (d == 0) a_valid = 1'b0; else b_valid = 1'b0;
    endtask

    task automatic wait_req(input int d, output int cyc);
        cyc = 0;
        while (g_req(d) !== 32'd1 && cyc < 100) begin
            @(negedge clock);
            cyc++;
        end
        chk("draw_req_seen", g_req(d), 1);
    endtask

    task automatic ack(input int d);
        if (d == 0) a_ack = 1'b1; else b_ack = 1'b1;
        @(negedge clock);
        if (d == 0) a_ack = 1'b0; else b_ack = 1'b0;
    endtask

    task automatic play(input int d, input int pos, input logic [1:0] sym);
        int cyc;
        offer(d, pos, sym);
        wait_req(d, cyc);
        chk("draw_pos", g_dpos(d), pos);
        chk("draw_sym", g_dsym(d), 32'(sym));
        ack(d);
        @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
    endtask

    int tie_pos [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
    logic [1:0] tie_sym [9] = '{SYM_X, SYM_O, SYM_X, SYM_X, SYM_O, SYM_O, SYM_O, SYM_X, SYM_X};
    int cyc;

    initial begin
        resetn = 1'b0;
        a_valid = 0; a_pos = 0; a_sym = 0; a_ack = 0; a_rdpos = 0;
        b_valid = 0; b_pos = 0; b_sym = 0; b_ack = 0; b_rdpos = 0;
`ifdef MISERE_UNDO_EN
        a_undo = 0; b_undo = 0;
`endif
        repeat (3) @(negedge clock);
        resetn = 1'b1;

        // reset state
        chk("rst_ready", g_ready(0), 1);
        chk("rst_cnt", g_cnt(0), 0);
        chk("rst_turn", g_turn(0), 0);
        chk("rst_over", g_over(0), 0);
        chk("rst_res", g_res(0), 0);
        chk("rst_req", g_req(0), 0);
        chk("rst_err", g_err(0), 0);
        chk("rst_b_ready", g_ready(1), 1);
        rd_chk(0, 0, SYM_EMPTY, "rst_cell0");

        // game 1: P1 loses on row 0
        play(0, 0, SYM_X);
        chk("g1_turn1", g_turn(0), 1);
        chk("g1_cnt1", g_cnt(0), 1);
        play(0, 4, SYM_O);
        chk("g1_turn2", g_turn(0), 0);

        offer(0, 4, SYM_X);
        chk("occ_err", g_err(0), 1);
        chk("occ_ready", g_ready(0), 1);
        chk("occ_cnt", g_cnt(0), 2);
        chk("occ_turn", g_turn(0), 0);
        rd_chk(0, 4, SYM_O, "occ_cell4");
        @(negedge clock);
        chk("occ_err_pulse_end", g_err(0), 0);
        offer(0, 5, 2'b00);
        chk("sym00_err", g_err(0), 1);
        offer(0, 5, 2'b11);
        chk("sym11_err", g_err(0), 1);
        offer(0, 9, SYM_X);
        chk("pos9_err", g_err(0), 1);
        rd_chk(0, 5, SYM_EMPTY, "err_cell5");
        chk("err_cnt", g_cnt(0), 2);

        play(0, 1, SYM_X);
        play(0, 8, SYM_O);
        chk("g1_over_pre", g_over(0), 0);
        play(0, 2, SYM_X);
        chk("g1_over", g_over(0), 1);
        chk("g1_res", g_res(0), 32'(RES_P2));
        chk("g1_cnt", g_cnt(0), 5);
        chk("g1_ready", g_ready(0), 0);
        rd_chk(0, 2, SYM_X, "g1_cell2");
        rd_chk(0, 9, SYM_EMPTY, "rd_out_of_range");
        offer(0, 3, SYM_O);
        chk("over_no_err", g_err(0), 0);
        chk("over_cnt", g_cnt(0), 5);
        chk("over_req", g_req(0), 0);

        // game 2: tie, first draw held for 20 cycles
        do_reset();
        chk("g2_rst_over", g_over(0), 0);
        offer(0, tie_pos[0], tie_sym[0]);
        wait_req(0, cyc);
        for (int i = 0; i < 20; i++) begin
            chk("hold_req", g_req(0), 1);
            chk("hold_pos", g_dpos(0), 0);
            chk("hold_sym", g_dsym(0), 32'(SYM_X));
            chk("hold_ready", g_ready(0), 0);
            @(negedge clock);
        end
        ack(0);
        @(negedge clock);
        chk("g2_turn1", g_turn(0), 1);
        ack(0);
        chk("stray_ack_cnt", g_cnt(0), 1);
        chk("stray_ack_ready", g_ready(0), 1);
        chk("stray_ack_turn", g_turn(0), 1);
        for (int i = 1; i < 8; i++) play(0, tie_pos[i], tie_sym[i]);
        chk("g2_over8", g_over(0), 0);
        chk("g2_res8", g_res(0), 0);
        play(0, tie_pos[8], tie_sym[8]);
        chk("g2_over", g_over(0), 1);
        chk("g2_res", g_res(0), 32'(RES_TIE));
        chk("g2_cnt", g_cnt(0), 9);

        // reset while scanning
        do_reset();
        offer(0, 4, SYM_X);
        @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        rd_chk(0, 4, SYM_EMPTY, "rscan_cell4");
        chk("rscan_req", g_req(0), 0);
        chk("rscan_ready", g_ready(0), 1);
        chk("rscan_cnt", g_cnt(0), 0);
        resetn = 1'b1;
        play(0, 4, SYM_X);
        chk("rscan_after_cnt", g_cnt(0), 1);

`ifdef MISERE_UNDO_EN
        do_reset();
        play(0, 0, SYM_X);
        play(0, 4, SYM_O);
        @(negedge clock);
        a_undo = 1'b1;
        @(negedge clock);
        a_undo = 1'b0;
        chk("undo_req", g_req(0), 1);
        chk("undo_dpos", g_dpos(0), 4);
        chk("undo_dsym", g_dsym(0), 0);
        chk("undo_cnt", g_cnt(0), 1);
        chk("undo_turn", g_turn(0), 1);
        rd_chk(0, 4, SYM_EMPTY, "undo_cell4");
        rd_chk(0, 0, SYM_X, "undo_cell0");
        ack(0);
        chk("undo_ready", g_ready(0), 1);
        chk("undo_req_done", g_req(0), 0);
        a_undo = 1'b1;
        @(negedge clock);
        a_undo = 1'b0;
        chk("undo2_err", g_err(0), 1);
        chk("undo2_cnt", g_cnt(0), 1);
        play(0, 4, SYM_X);
        chk("undo_replay_cnt", g_cnt(0), 2);
`endif

        // game 3 (5x5, run of 4): P2 completes the anti-diagonal 3,7,11,15
        do_reset();
        play(1, 0, SYM_X);
        play(1, 3, SYM_O);
        play(1, 24, SYM_X);
        play(1, 7, SYM_O);
        play(1, 20, SYM_X);
        play(1, 11, SYM_O);
        play(1, 4, SYM_X);
        chk("g3_over_pre", g_over(1), 0);
        chk("g3_turn", g_turn(1), 1);
        offer(1, 15, SYM_O);
        wait_req(1, cyc);
        chk("g3_scan_le24", 32'((cyc - 1) <= 24), 1);
        ack(1);
        chk("g3_over", g_over(1), 1);
        chk("g3_res", g_res(1), 32'(RES_P1));
        chk("g3_cnt", g_cnt(1), 8);
        rd_chk(1, 15, SYM_O, "g3_cell15");
        rd_chk(1, 25, SYM_EMPTY, "g3_rd_oor");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
